// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC register, IF/ID pipeline register,
// and saturating stall/flush counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pc_write,
    input  logic        i_if_id_write,
    input  logic        i_if_flush,
    input  logic        i_pc_src,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_imem_instr,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc_plus4,
    output logic        o_if_id_valid,
    output logic [15:0] o_stall_count,
    output logic [15:0] o_flush_count
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc_plus4;
    logic        r_if_id_valid;
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_next  = i_pc_src ? {i_branch_target[31:2], 2'b00} : w_pc_plus4;

    // A stalled PC ignores pc_src; ID holds the redirect until the stall clears.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_pc_write) begin
            r_pc <= w_pc_next;
        end
    end

    // Flush beats a stalled IF/ID so a squashed instruction never survives a stall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_if_id_instr    <= 32'h0000_0000;
            r_if_id_pc_plus4 <= 32'h0000_0000;
            r_if_id_valid    <= 1'b0;
        end else if (i_if_flush) begin
            r_if_id_instr    <= 32'h0000_0000;
            r_if_id_pc_plus4 <= 32'h0000_0000;
            r_if_id_valid    <= 1'b0;
        end else if (i_if_id_write) begin
            r_if_id_instr    <= i_imem_instr;
            r_if_id_pc_plus4 <= w_pc_plus4;
            r_if_id_valid    <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_count <= 16'h0000;
            r_flush_count <= 16'h0000;
        end else begin
            if (!i_pc_write && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (i_if_flush && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign o_imem_addr      = r_pc;
    assign o_pc             = r_pc;
    assign o_if_id_instr    = r_if_id_instr;
    assign o_if_id_pc_plus4 = r_if_id_pc_plus4;
    assign o_if_id_valid    = r_if_id_valid;
    assign o_stall_count    = r_stall_count;
    assign o_flush_count    = r_flush_count;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector bench for if_stage.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        if_id_write;
    logic        if_flush;
    logic        pc_src;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int checks;
    int failures;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_pc_write       (pc_write),
        .i_if_id_write    (if_id_write),
        .i_if_flush       (if_flush),
        .i_pc_src         (pc_src),
        .i_branch_target  (branch_target),
        .i_imem_instr     (imem_instr),
        .o_imem_addr      (imem_addr),
        .o_pc             (pc),
        .o_if_id_instr    (if_id_instr),
        .o_if_id_pc_plus4 (if_id_pc_plus4),
        .o_if_id_valid    (if_id_valid),
        .o_stall_count    (stall_count),
        .o_flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: a fixed scramble of the address, never zero for the addresses used.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign imem_instr = mem_f(imem_addr);

    typedef struct {
        logic        pw;
        logic        iw;
        logic        fl;
        logic        src;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [15:0] e_stall;
        logic [15:0] e_flush;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic pw, input logic iw, input logic fl, input logic src,
                                input logic [31:0] tgt, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic [31:0] e_pc4,
                                input logic e_valid, input logic [15:0] e_stall,
                                input logic [15:0] e_flush);
        vec_t v;
        v.pw = pw; v.iw = iw; v.fl = fl; v.src = src; v.tgt = tgt;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
        v.e_stall = e_stall; v.e_flush = e_flush;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_ctrl(input logic pw, input logic iw, input logic fl, input logic src,
                            input logic [31:0] tgt);
        pc_write = pw; if_id_write = iw; if_flush = fl; pc_src = src; branch_target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          sat_bad;
    logic [15:0] sat_exp;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        vecs[0]  = mk(1,1,0,0,32'h0,        32'h0000_0000+4, mem_f(32'h00), 32'h04, 1, 0, 0);
        vecs[1]  = mk(1,1,0,0,32'h0,        32'h08,          mem_f(32'h04), 32'h08, 1, 0, 0);
        vecs[2]  = mk(1,1,0,0,32'h0,        32'h0C,          mem_f(32'h08), 32'h0C, 1, 0, 0);
        vecs[3]  = mk(1,1,0,0,32'h0,        32'h10,          mem_f(32'h0C), 32'h10, 1, 0, 0);
        vecs[4]  = mk(0,0,0,0,32'h0,        32'h10,          mem_f(32'h0C), 32'h10, 1, 1, 0);
        vecs[5]  = mk(1,1,0,0,32'h0,        32'h14,          mem_f(32'h10), 32'h14, 1, 1, 0);
        vecs[6]  = mk(1,1,0,0,32'h0,        32'h18,          mem_f(32'h14), 32'h18, 1, 1, 0);
        vecs[7]  = mk(1,1,0,0,32'h0,        32'h1C,          mem_f(32'h18), 32'h1C, 1, 1, 0);
        vecs[8]  = mk(1,1,0,0,32'h0,        32'h20,          mem_f(32'h1C), 32'h20, 1, 1, 0);
        vecs[9]  = mk(1,1,1,1,32'h43,       32'h40,          32'h0,         32'h00, 0, 1, 1);
        vecs[10] = mk(1,1,0,0,32'h0,        32'h44,          mem_f(32'h40), 32'h44, 1, 1, 1);
        vecs[11] = mk(1,1,0,1,32'h30,       32'h30,          mem_f(32'h44), 32'h48, 1, 1, 1);
        vecs[12] = mk(0,0,1,1,32'h80,       32'h30,          32'h0,         32'h00, 0, 2, 2);
        vecs[13] = mk(1,1,0,0,32'h0,        32'h34,          mem_f(32'h30), 32'h34, 1, 2, 2);
        vecs[14] = mk(1,1,0,1,32'hFFFF_FFFF,32'hFFFF_FFFC,   mem_f(32'h34), 32'h38, 1, 2, 2);
        vecs[15] = mk(1,1,0,0,32'h0,        32'h00,          mem_f(32'hFFFF_FFFC), 32'h00, 1, 2, 2);
        vecs[16] = mk(1,0,0,0,32'h0,        32'h04,          mem_f(32'hFFFF_FFFC), 32'h00, 1, 2, 2);
        vecs[17] = mk(0,1,0,0,32'h0,        32'h04,          mem_f(32'h04), 32'h08, 1, 3, 2);

        #12;
        rst = 1'b0;
        step();
        step();
        step();
        // Asynchronous mid-run reset: state clears without any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_imem_addr", imem_addr, 32'h0);
        chk("async_rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("async_rst_instr", if_id_instr, 32'h0);
        chk("async_rst_pc4", if_id_pc_plus4, 32'h0);
        chk("async_rst_stall", {16'b0, stall_count}, 32'h0);
        chk("async_rst_flush", {16'b0, flush_count}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        for (int i = 0; i < 18; i++) begin
            set_ctrl(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].src, vecs[i].tgt);
            step();
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), if_id_instr, vecs[i].e_instr);
            chk($sformatf("v%0d_pc4", i), if_id_pc_plus4, vecs[i].e_pc4);
            chk($sformatf("v%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_stall", i), {16'b0, stall_count}, {16'b0, vecs[i].e_stall});
            chk($sformatf("v%0d_flush", i), {16'b0, flush_count}, {16'b0, vecs[i].e_flush});
        end

        // Reset with a pending redirect and flush: both are discarded.
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_redirect_pc", pc, 32'h0);
        chk("rst_redirect_flush", {16'b0, flush_count}, 32'h0);
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_pc", pc, 32'h04);
        chk("post_rst_instr", if_id_instr, mem_f(32'h0));
        chk("post_rst_pc4", if_id_pc_plus4, 32'h04);

        // Stall counter saturation over a long stall; PC must not move.
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        sat_bad = 0;
        for (int i = 0; i < 70000; i++) begin
            step();
            sat_exp = (i >= 65534) ? 16'hFFFF : 16'(i + 1);
            if (stall_count !== sat_exp || pc !== 32'h04) begin
                if (sat_bad == 0)
                    $display("FAIL sat_cycle%0d: stall %h pc %h expected stall %h pc 00000004",
                             i, stall_count, pc, sat_exp);
                sat_bad++;
            end
        end
        chk("sat_any_cycle_bad", sat_bad, 0);
        chk("sat_final_stall", {16'b0, stall_count}, 32'h0000_FFFF);
        chk("sat_final_pc", pc, 32'h04);
        chk("sat_final_instr", if_id_instr, mem_f(32'h0));

        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("sat_release_pc", pc, 32'h08);
        chk("sat_release_stall_hold", {16'b0, stall_count}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the 32-bit MIPS pipeline. It consumes the stall controls (`pc_write`, `if_id_write`) produced by hazard detection and the redirect/flush controls from branch resolution in ID. It owns the program counter and the IF/ID pipeline register. It drives the instruction-memory address and presents a registered instruction, PC+4 and valid bit to the decode stage, plus saturating stall/flush counters for performance debug.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_write`  in  1  1 = PC may update this edge; 0 = hold PC (stall).
- `if_id_write`  in  1  1 = IF/ID may load; 0 = hold IF/ID (stall).
- `if_flush`  in  1  1 = replace IF/ID contents with a bubble this edge.
- `pc_src`  in  1  1 = next PC is `branch_target`; 0 = PC+4.
- `branch_target`  in  32  redirect address from ID; bits [1:0] ignored (forced 0).
- `imem_instr`  in  32  instruction word at `imem_addr`; combinational-read memory, valid in the same cycle.
- `imem_addr`  out  32  equals `pc`.
- `pc`  out  32  current fetch PC (registered).
- `if_id_instr`  out  32  registered instruction for ID.
- `if_id_pc_plus4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  1 = IF/ID holds a real fetched instruction.
- `stall_count`  out  16  cycles with `pc_write`=0 since reset, saturating.
- `flush_count`  out  16  edges with `if_flush`=1 since reset, saturating.

## Operation
- `pc_plus4` = `pc` + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- `pc_next` = `pc_src` ? {`branch_target`[31:2], 2'b00} : `pc_plus4`.
- PC register: loads `pc_next` on an edge when `pc_write`=1. When `pc_write`=0 it holds, and `pc_src` is ignored that edge. ID keeps the branch and `pc_src` asserted until the stall clears, so no redirect is lost.
- IF/ID register, in priority order per edge:
  1. `if_flush`=1: `if_id_instr`=32'h0000_0000 (NOP), `if_id_pc_plus4`=0, `if_id_valid`=0. This applies even when `if_id_write`=0.
  2. Else if `if_id_write`=1: `if_id_instr`=`imem_instr`, `if_id_pc_plus4`=`pc_plus4`, `if_id_valid`=1.
  3. Else: hold all three.
- `stall_count`: +1 on each edge where `pc_write`=0; holds at 16'hFFFF.
- `flush_count`: +1 on each edge where `if_flush`=1; holds at 16'hFFFF.
- `pc_write` and `if_id_write` are independent inputs; the block does not require them to be equal.

## Timing
- Reset (asynchronous, takes effect immediately, no clock needed):
  - `pc`=`imem_addr`=`RESET_PC`
  - `if_id_instr`=0, `if_id_pc_plus4`=0, `if_id_valid`=0
  - `stall_count`=0, `flush_count`=0
- Reset asserted mid-operation discards any in-flight fetch and redirect.
- First edge after reset release, with all controls at 1/0 defaults: IF/ID captures the word at `RESET_PC`, `if_id_pc_plus4`=`RESET_PC`+4, and `pc` becomes `RESET_PC`+4.
- Fetch latency is 1 cycle: the word addressed by `pc` in cycle N appears on `if_id_instr` in cycle N+1.
- Redirect latency is 1 cycle: with `pc_src`=1 and `pc_write`=1 at edge N, `pc`=target after edge N, and the target word reaches IF/ID at edge N+1.
- Branch-taken sequence: ID asserts `pc_src`=1 and `if_flush`=1 in the same cycle, which yields exactly one bubble.
- All outputs are registered except `imem_addr`, which is a direct copy of `pc`.

## Test plan
1. Reset and sequential fetch: `RESET_PC`=0; pulse `rst` mid-run. Required: `pc`=0 and `if_id_valid`=0 immediately, before any clock edge. Release, then 3 edges: `pc`=0x0C, `if_id_pc_plus4`=0x0C, `if_id_instr`=mem[0x08], `if_id_valid`=1.
2. Load-use stall: at `pc`=0x10, hold `pc_write`=`if_id_write`=0 for 1 cycle. Required: `pc` stays 0x10, IF/ID still holds mem[0x0C] with `if_id_pc_plus4`=0x10, `stall_count`=1. The next edge gives `pc`=0x14 and `if_id_instr`=mem[0x10].
3. Taken branch: at `pc`=0x20, assert `pc_src`=1, `branch_target`=0x43, `if_flush`=1. Required after the edge: `pc`=0x40, `if_id_instr`=0, `if_id_valid`=0, `flush_count`=1. Next edge: `if_id_instr`=mem[0x40], `if_id_pc_plus4`=0x44.
4. Flush during stall: `pc_write`=0, `if_id_write`=0, `if_flush`=1, `pc_src`=1 (target 0x80) at `pc`=0x30. Required: `pc` stays 0x30 (redirect ignored), IF/ID cleared with `if_id_valid`=0, `stall_count` and `flush_count` each +1.
5. Wrap-around: force `pc`=0xFFFF_FFFC through the branch path. Required next edge: `pc`=0x0000_0000, `if_id_pc_plus4`=0x0000_0000, `if_id_instr`=mem[0xFFFF_FFFC].
6. Saturation: hold `pc_write`=0 for 70000 cycles. Required: `stall_count`=16'hFFFF, staying at that value; `pc` unchanged throughout.
